// File: rtl/bf_sched.sv
// rtl/bf_sched.sv - round-robin scheduler sharing one butterfly network among N_REQ requesters
// Define BF_SCHED_STATS_EN to add per-requester saturating grant counters (grant_cnt, stats_clr).
module bf_sched #(
   parameter int N_REQ       = 4,
   parameter int ID_WIDTH    = 2,
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 2,
   parameter int CFG_LEAD    = 2,
   parameter int NET_LATENCY = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ-1:0]              req_last,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic [N_REQ*4*ADDR_WIDTH-1:0] req_addr,
   output logic [ADDR_WIDTH-1:0]         bf_addr_A,
   output logic [ADDR_WIDTH-1:0]         bf_addr_B,
   output logic [ADDR_WIDTH-1:0]         bf_addr_C,
   output logic [ADDR_WIDTH-1:0]         bf_addr_D,
   output logic                          bf_dval_i,
   output logic [DATA_WIDTH-1:0]         bf_data_i,
   input  logic                          bf_dval_o,
   input  logic [DATA_WIDTH-1:0]         bf_data_o,
   output logic                          rsp_valid,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic                          rsp_last,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   input  logic                          flush_req,
   output logic                          flush_done,
   output logic                          busy
`ifdef BF_SCHED_STATS_EN
   ,
   input  logic                          stats_clr,
   output logic [N_REQ*16-1:0]           grant_cnt
`endif
);

   localparam int CW        = $clog2(CFG_LEAD + NET_LATENCY + 2) + 1;
   localparam int DAT_DEPTH = CFG_LEAD + 1;
   localparam int TAG_DEPTH = CFG_LEAD + NET_LATENCY + 1;

   typedef enum logic [1:0] {IDLE, LOCK, FLUSH} state_t;

   state_t                    state, state_nxt;
   logic [ID_WIDTH-1:0]       rr_ptr;
   logic                      flush_pend;
   logic [CW-1:0]             inflight;
   logic [ID_WIDTH-1:0]       win, acc_idx;
   logic                      win_found, accept, acc_last;
   logic [N_REQ-1:0]          ready;
   logic [DATA_WIDTH-1:0]     data_arr [N_REQ];
   logic [4*ADDR_WIDTH-1:0]   addr_arr [N_REQ];
   logic [DATA_WIDTH:0]       dat_q [DAT_DEPTH];
   logic [ID_WIDTH:0]         tag_q [TAG_DEPTH];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign addr_arr[g] = req_addr[g*4*ADDR_WIDTH +: 4*ADDR_WIDTH];
   end

   // Search from rr_ptr+1 upward; iterating downward lets the nearest candidate win.
   always_comb begin
      int idx;
      idx       = 0;
      win       = rr_ptr;
      win_found = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (req_valid[ID_WIDTH'(idx)]) begin
            win       = ID_WIDTH'(idx);
            win_found = 1'b1;
         end
      end
   end

   assign acc_idx  = (state == LOCK) ? rr_ptr : win;
   assign accept   = |(req_ready & req_valid);
   assign acc_last = req_last[acc_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (flush_pend)            state_nxt = FLUSH;
                  else if (accept && !acc_last) state_nxt = LOCK;
         LOCK:    if (accept && acc_last)    state_nxt = IDLE;
         FLUSH:   if (inflight == '0)        state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = '0;
      if (state == LOCK)
         ready[rr_ptr] = 1'b1;
      else if (state == IDLE && !flush_pend && win_found)
         ready[win] = 1'b1;
      req_ready  = rst ? ready : '0;
      flush_done = (state == FLUSH) && (inflight == '0);
      busy       = (state != IDLE) || (inflight != '0);
   end

   // rr_ptr doubles as the lock owner: the grant that enters LOCK also sets it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr     <= ID_WIDTH'(N_REQ - 1);
         flush_pend <= 1'b0;
         inflight   <= '0;
      end else begin
         if (accept) rr_ptr <= acc_idx;
         if (state == IDLE && flush_pend)
            flush_pend <= 1'b0;
         else if (flush_req && state != FLUSH)
            flush_pend <= 1'b1;
         if (accept && !bf_dval_o && inflight != {CW{1'b1}})
            inflight <= inflight + 1'b1;
         else if (bf_dval_o && !accept && inflight != '0)
            inflight <= inflight - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bf_addr_A <= '0;
         bf_addr_B <= '0;
         bf_addr_C <= '0;
         bf_addr_D <= '0;
         for (int i = 0; i < DAT_DEPTH; i++) dat_q[i] <= '0;
         for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
      end else begin
         if (accept) begin
            bf_addr_A <= addr_arr[acc_idx][4*ADDR_WIDTH-1 -: ADDR_WIDTH];
            bf_addr_B <= addr_arr[acc_idx][3*ADDR_WIDTH-1 -: ADDR_WIDTH];
            bf_addr_C <= addr_arr[acc_idx][2*ADDR_WIDTH-1 -: ADDR_WIDTH];
            bf_addr_D <= addr_arr[acc_idx][ADDR_WIDTH-1 -: ADDR_WIDTH];
         end
         dat_q[0] <= accept ? {1'b1, data_arr[acc_idx]} : '0;
         tag_q[0] <= accept ? {acc_idx, acc_last} : '0;
         for (int i = 1; i < DAT_DEPTH; i++) dat_q[i] <= dat_q[i-1];
         for (int i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign bf_dval_i = dat_q[DAT_DEPTH-1][DATA_WIDTH];
   assign bf_data_i = dat_q[DAT_DEPTH-1][DATA_WIDTH-1:0];
   assign rsp_valid = bf_dval_o;
   assign rsp_data  = bf_data_o;
   assign rsp_id    = tag_q[TAG_DEPTH-1][ID_WIDTH:1];
   assign rsp_last  = tag_q[TAG_DEPTH-1][0];

`ifdef BF_SCHED_STATS_EN
   logic [15:0] cnt_q [N_REQ];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      end else if (stats_clr) begin
         for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      end else if (accept && cnt_q[acc_idx] != 16'hFFFF) begin
         cnt_q[acc_idx] <= cnt_q[acc_idx] + 16'd1;
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
      assign grant_cnt[g*16 +: 16] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_bf_sched.sv
// tb/tb_bf_sched.sv - directed self-checking bench for bf_sched with a 2-stage network model
// Exercises the stats counters when BF_SCHED_STATS_EN is defined.
module tb_bf_sched;
   localparam int NL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_valid, req_ready, req_last;
   logic [63:0] req_data;
   logic [31:0] req_addr;
   logic [1:0]  bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D;
   logic        bf_dval_i, bf_dval_o;
   logic [15:0] bf_data_i, bf_data_o;
   logic        rsp_valid, rsp_last;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        flush_req, flush_done, busy;
`ifdef BF_SCHED_STATS_EN
   logic        stats_clr = 1'b0;
   logic [63:0] grant_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cnt;

   always #5 clk = ~clk;

   bf_sched dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
      .req_data(req_data), .req_addr(req_addr),
      .bf_addr_A(bf_addr_A), .bf_addr_B(bf_addr_B), .bf_addr_C(bf_addr_C), .bf_addr_D(bf_addr_D),
      .bf_dval_i(bf_dval_i), .bf_data_i(bf_data_i), .bf_dval_o(bf_dval_o), .bf_data_o(bf_data_o),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_data(rsp_data),
      .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
`ifdef BF_SCHED_STATS_EN
      , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
   );

   // Network stand-in: NL register stages, data scrambled by a fixed XOR, reset with the scheduler.
   logic [16:0] net_q [NL];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NL; i++) net_q[i] <= '0;
      end else begin
         net_q[0] <= {bf_dval_i, bf_data_i ^ 16'hA5A5};
         for (int i = 1; i < NL; i++) net_q[i] <= net_q[i-1];
      end
   end
   assign bf_dval_o = net_q[NL-1][16];
   assign bf_data_o = net_q[NL-1][15:0];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_addrA"}, 64'(bf_addr_A), 64'd0);
      check({tag, "_addrD"}, 64'(bf_addr_D), 64'd0);
      check({tag, "_dval"}, 64'(bf_dval_i), 64'd0);
      check({tag, "_data"}, 64'(bf_data_i), 64'd0);
      check({tag, "_rspid"}, 64'(rsp_id), 64'd0);
      check({tag, "_rsplast"}, 64'(rsp_last), 64'd0);
      check({tag, "_done"}, 64'(flush_done), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      req_valid = '0; req_last = '0; req_data = '0; req_addr = '0; flush_req = 1'b0;

      // Reset with requests pending: nothing granted, outputs at reset values
      req_valid = 4'hF;
      repeat (2) step;
      settle;
      check_reset_outputs("rst");
      step;
      req_valid = '0;
      rst = 1'b1;

      // Single beat from requester 2, addr {1,2,3,0}
      req_valid = 4'b0100; req_last = 4'b0100;
      req_data[47:32] = 16'h1234; req_addr[23:16] = 8'h6C;
      settle; check("sb_ready", 64'(req_ready), 64'h4);
      step; req_valid = '0;
      settle;
      check("sb_addrA", 64'(bf_addr_A), 64'd1);
      check("sb_addrB", 64'(bf_addr_B), 64'd2);
      check("sb_addrC", 64'(bf_addr_C), 64'd3);
      check("sb_addrD", 64'(bf_addr_D), 64'd0);
      check("sb_busy", 64'(busy), 64'd1);
      check("sb_dval_t1", 64'(bf_dval_i), 64'd0);
      step; settle; check("sb_dval_t2", 64'(bf_dval_i), 64'd0);
      step; settle;
      check("sb_dval_t3", 64'(bf_dval_i), 64'd1);
      check("sb_data_t3", 64'(bf_data_i), 64'h1234);
      check("sb_addr_hold", 64'(bf_addr_C), 64'd3);
      step; settle; check("sb_rsp_t4", 64'(rsp_valid), 64'd0);
      step; settle;
      check("sb_rsp_t5", 64'(rsp_valid), 64'd1);
      check("sb_rspid", 64'(rsp_id), 64'd2);
      check("sb_rsplast", 64'(rsp_last), 64'd1);
      check("sb_rspdata", 64'(rsp_data), 64'hB791);
      step; settle;
      check("sb_idle_busy", 64'(busy), 64'd0);
      check("sb_dval_after", 64'(bf_dval_i), 64'd0);

      // Round robin from a fresh reset
      rst = 1'b0; step; rst = 1'b1;
      req_valid = 4'hF; req_last = 4'hF;
      req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      for (int k = 0; k < 5; k++) begin
         settle; check("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
         step;
      end
      req_valid = '0;
      for (int k = 0; k < 5; k++) begin
         settle;
         check("rr_rspvalid", 64'(rsp_valid), 64'd1);
         check("rr_rspid", 64'(rsp_id), 64'(k % 4));
         if (k == 0) check("rr_rspdata", 64'(rsp_data), 64'hB5A5);
         step;
      end
      settle; check("rr_busy_end", 64'(busy), 64'd0);
      step;

      // Packet lock: requester 1 three beats with a gap, requester 0 waiting
      req_valid = 4'b0011; req_last = 4'b0001;
      settle; check("lk_b1", 64'(req_ready), 64'h2); step;
      req_valid = 4'b0001;
      settle; check("lk_gap", 64'(req_ready), 64'h2); step;
      req_valid = 4'b0011;
      settle; check("lk_b2", 64'(req_ready), 64'h2); step;
      req_last = 4'b0011;
      settle; check("lk_b3", 64'(req_ready), 64'h2); step;
      req_valid = 4'b0001;
      settle; check("lk_r0_next", 64'(req_ready), 64'h1); step;
      req_valid = '0;
      settle;
      check("lk_rsp1_v", 64'(rsp_valid), 64'd1);
      check("lk_rsp1_id", 64'(rsp_id), 64'd1);
      check("lk_rsp1_last", 64'(rsp_last), 64'd0);
      step; settle; check("lk_rsp_gap", 64'(rsp_valid), 64'd0);
      step; settle; check("lk_rsp2_last", 64'(rsp_last), 64'd0);
      step; settle;
      check("lk_rsp3_id", 64'(rsp_id), 64'd1);
      check("lk_rsp3_last", 64'(rsp_last), 64'd1);
      step; settle;
      check("lk_rsp4_id", 64'(rsp_id), 64'd0);
      check("lk_rsp4_last", 64'(rsp_last), 64'd1);
      step; settle; check("lk_busy_end", 64'(busy), 64'd0);
      step;

      // Flush during a locked packet from requester 2, requester 3 waiting
      req_valid = 4'b1100; req_last = 4'b1000;
      settle; check("fl_b1", 64'(req_ready), 64'h4); step;
      flush_req = 1'b1; req_last = 4'b1100;
      settle; check("fl_b2", 64'(req_ready), 64'h4); step;
      flush_req = 1'b0;
      settle; check("fl_nogrant", 64'(req_ready), 64'h0); step;
      for (int j = 3; j <= 6; j++) begin
         settle;
         check("fl_ready_flush", 64'(req_ready), 64'h0);
         check("fl_done_early", 64'(flush_done), 64'd0);
         if (j == 6) begin
            check("fl_last_rsp", 64'(rsp_valid), 64'd1);
            check("fl_last_rsplast", 64'(rsp_last), 64'd1);
         end
         step;
      end
      req_valid = '0;
      settle;
      check("fl_done", 64'(flush_done), 64'd1);
      check("fl_busy_done", 64'(busy), 64'd1);
      step;
      cnt = 0;
      for (int j = 0; j < 4; j++) begin
         settle;
         if (j == 0) check("fl_busy_low", 64'(busy), 64'd0);
         cnt += int'(flush_done);
         step;
      end
      check("fl_done_once", 64'(cnt), 64'd0);

      // Reset in the middle of a packet from requester 0
      req_valid = 4'b0001; req_last = 4'b0000;
      req_data[15:0] = 16'h7777; req_addr[7:0] = 8'hFF;
      settle; check("mr_b1", 64'(req_ready), 64'h1); step;
      settle; check("mr_b2", 64'(req_ready), 64'h1); step;
      settle; check("mr_addr_pre", 64'(bf_addr_A), 64'd3);
      rst = 1'b0; req_valid = '0;
      #1;
      check_reset_outputs("mr");
      step; rst = 1'b1;
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
         settle;
         cnt += int'(rsp_valid) + int'(bf_dval_i);
         step;
      end
      check("mr_no_rsp", 64'(cnt), 64'd0);

`ifdef BF_SCHED_STATS_EN
      rst = 1'b0; step;
      settle; check("st_reset", grant_cnt, 64'd0);
      step; rst = 1'b1;
      req_valid = 4'b1000; req_last = 4'b1000;
      repeat (70000) step;
      req_valid = '0;
      settle;
      check("st_sat", 64'(grant_cnt[63:48]), 64'hFFFF);
      check("st_others", 64'(grant_cnt[47:0]), 64'd0);
      step; stats_clr = 1'b1;
      step; stats_clr = 1'b0;
      settle; check("st_clr", grant_cnt, 64'd0);
      step;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
